// File: rtl/alu_sched.sv
// ---------------------------------------------------------------------------
// Module  : alu_sched
// Purpose : Two-requester round-robin front end to a single-issue ALU with
//           condition-code register and a 3-state IDLE/EXEC/RESP handshake.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_sched #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req0_op,
  input  logic [1:0]   req1_op,
  input  logic         req0_setcc,
  input  logic         req1_setcc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic [2:0]   rsp_cc,
  output logic [2:0]   cc_q,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_AND = 2'b10;

  state_t         r_state;
  logic           r_last;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [1:0]     r_op;
  logic           r_setcc;
  logic           r_id;

  logic [1:0]     w_grant;
  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_diff;
  logic [W-1:0]   w_res;
  logic           w_of;
  logic [2:0]     w_flags;

  // r_last names the requester served most recently; on a tie the other wins.
  always_comb begin
    w_grant = 2'b00;
    if (!rst && r_state == IDLE) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign busy      = !rst && (r_state != IDLE);

  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;

  always_comb begin
    w_res = w_sum;
    w_of  = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_res = w_sum;
        w_of  = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_of  = (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
      end
      c_OP_AND: w_res = r_a & r_b;
      default:  w_res = r_a ^ r_b;
    endcase
  end

  assign w_flags = {(w_res == '0), w_res[W-1], w_of};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 2'b00;
      r_setcc   <= 1'b0;
      r_id      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_cc    <= 3'b000;
      rsp_id    <= 1'b0;
      cc_q      <= 3'b100;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != 2'b00) begin
            r_id    <= w_grant[1];
            r_last  <= w_grant[1];
            r_a     <= w_grant[1] ? req1_a     : req0_a;
            r_b     <= w_grant[1] ? req1_b     : req0_b;
            r_op    <= w_grant[1] ? req1_op    : req0_op;
            r_setcc <= w_grant[1] ? req1_setcc : req0_setcc;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= w_res;
          rsp_cc    <= w_flags;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          if (r_setcc) begin
            cc_q <= w_flags;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sched.sv
// ---------------------------------------------------------------------------
// Module  : tb_alu_sched
// Purpose : Scoreboard bench for alu_sched: directed cases plus random traffic
//           against a behavioural arbitration/ALU model.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_sched;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic         req0_setcc, req1_setcc;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_cc, cc_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic [2:0]   cc;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_sched #(.W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_setcc(req0_setcc), .req1_setcc(req1_setcc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cc(rsp_cc), .cc_q(cc_q), .busy(busy)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags from signed arithmetic on one extra bit: overflow iff the true
  // sum/difference is not representable in W bits.
  task automatic ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         output logic [W-1:0] r, output logic [2:0] cc);
    logic signed [W:0] wide;
    logic of;
    of = 1'b0;
    r  = '0;
    case (op)
      2'b00: begin
        wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
        r = wide[W-1:0];
        of = (wide > $signed({2'b00, {(W-1){1'b1}}})) || (wide < -$signed({2'b01, {(W-1){1'b0}}}));
      end
      2'b01: begin
        wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
        r = wide[W-1:0];
        of = (wide > $signed({2'b00, {(W-1){1'b1}}})) || (wide < -$signed({2'b01, {(W-1){1'b0}}}));
      end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
    cc = {(r == '0), r[W-1], of};
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last_served);
    if (v == 2'b11) return last_served ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Reference model: phase 0 idle, 1 executing, 2 presenting a result.
  int         phase = 0;
  logic       mlast = 1'b1;
  logic [2:0] mcc = 3'b100;
  logic [2:0] pend_cc;
  logic       pend_set;
  logic       post_rst = 1'b0;

  always @(negedge clk) begin
    logic [1:0]   g;
    logic [W-1:0] r;
    logic [2:0]   f;
    exp_t         e;
    if (rst) begin
      chk("rst_ready", W'(req_ready), W'(2'b00));
      chk("rst_busy", W'(busy), W'(1'b0));
      phase = 0; mlast = 1'b1; mcc = 3'b100; post_rst = 1'b1;
      sbq.delete();
    end else begin
      if (post_rst) begin
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_cc", W'(rsp_cc), W'(3'b000));
        chk("rst_rsp_id", W'(rsp_id), W'(1'b0));
        post_rst = 1'b0;
      end
      chk("busy", W'(busy), W'(phase != 0));
      chk("rsp_valid", W'(rsp_valid), W'(phase == 2));
      chk("cc_q", W'(cc_q), W'(mcc));
      g = (phase == 0) ? exp_grant(req_valid, mlast) : 2'b00;
      chk("req_ready", W'(req_ready), W'(g));
      case (phase)
        0: if (g != 2'b00) begin
          if (g[1]) ref_alu(req1_a, req1_b, req1_op, r, f);
          else      ref_alu(req0_a, req0_b, req0_op, r, f);
          e.id = g[1]; e.data = r; e.cc = f;
          sbq.push_back(e);
          pend_cc = f;
          pend_set = g[1] ? req1_setcc : req0_setcc;
          mlast = g[1];
          phase = 1;
        end
        1: begin
          if (pend_set) mcc = pend_cc;
          phase = 2;
        end
        default: if (rsp_ready) phase = 0;
      endcase
    end
  end

  // Monitor: every cycle a result is presented it must match the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got data %h with empty scoreboard at %0t", rsp_data, $time);
      end else begin
        chk("sb_id", W'(rsp_id), W'(sbq[0].id));
        chk("sb_data", rsp_data, sbq[0].data);
        chk("sb_cc", W'(rsp_cc), W'(sbq[0].cc));
        if (rsp_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic sc);
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_setcc = sc; end
    else         begin req1_a = a; req1_b = b; req1_op = op; req1_setcc = sc; end
    req_valid[id] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL issue_timeout: requester %0d got no grant, required one within 50 cycles", id);
    req_valid[id] = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic id, input logic [W-1:0] data,
                            input logic [2:0] cc, input logic [2:0] ccq);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    chk({name, "_latency"}, W'(n), W'(2));
    chk({name, "_id"}, W'(rsp_id), W'(id));
    chk({name, "_data"}, rsp_data, data);
    chk({name, "_cc"}, W'(rsp_cc), W'(cc));
    chk({name, "_ccq"}, W'(cc_q), W'(ccq));
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {1'b0, {(W-1){1'b1}}};
      2: return {1'b1, {(W-1){1'b0}}};
      3: return '1;
      4: return W'(1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] gseq[$];
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_op = 2'b00; req1_op = 2'b00; req0_setcc = 1'b0; req1_setcc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(0, 64'd5, -64'sd5, 2'b00, 1'b1);
    expect_rsp("add_zero", 1'b0, '0, 3'b100, 3'b100);
    issue(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1);
    expect_rsp("add_of", 1'b1, 64'h8000_0000_0000_0000, 3'b011, 3'b011);
    issue(1, 64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b1);
    expect_rsp("sub_of", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 3'b001);
    issue(0, 64'd3, 64'd3, 2'b11, 1'b0);
    expect_rsp("xor_nocc", 1'b0, '0, 3'b100, 3'b001);

    // Backpressure: hold the result for a long stall with both requesters pushing.
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(0, 64'd10, 64'd20, 2'b00, 1'b1);
    @(posedge clk); #1 req_valid = 2'b11;
    repeat (12) @(negedge clk);
    chk("stall_ready", W'(req_ready), W'(2'b00));
    chk("stall_data", rsp_data, 64'd30);
    @(posedge clk); #1 rsp_ready = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("stall_release_idle", W'(busy), W'(1'b0));

    // Arbitration from reset with both requesters continuously valid.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0_a = 64'd1; req0_b = 64'd1; req0_op = 2'b00; req0_setcc = 1'b1;
    req1_a = 64'd2; req1_b = 64'd2; req1_op = 2'b00; req1_setcc = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("ready_onehot", W'(req_ready == 2'b11), W'(1'b0));
      if (req_ready != 2'b00) gseq.push_back(req_ready);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    chk("arb_g0", W'(gseq[0]), W'(2'b01));
    chk("arb_g1", W'(gseq[1]), W'(2'b10));
    chk("arb_g2", W'(gseq[2]), W'(2'b01));
    chk("arb_g3", W'(gseq[3]), W'(2'b10));

    // Reset while the operation is in EXEC: its result must never appear.
    issue(0, 64'd7, 64'd8, 2'b00, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", W'(rsp_valid), W'(1'b0));
    chk("midrst_ccq", W'(cc_q), W'(3'b100));
    chk("midrst_busy", W'(busy), W'(1'b0));
    repeat (4) @(negedge clk);
    chk("midrst_never_valid", W'(rsp_valid), W'(1'b0));

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 149) == 0);
      req_valid  = 2'($urandom_range(0, 3));
      req0_a     = rnd_val(); req0_b = rnd_val();
      req1_a     = rnd_val(); req1_b = rnd_val();
      req0_op    = 2'($urandom_range(0, 3));
      req1_op    = 2'($urandom_range(0, 3));
      req0_setcc = 1'($urandom_range(0, 1));
      req1_setcc = 1'($urandom_range(0, 1));
      rsp_ready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 rst = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", W'(sbq.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter W, default 64, the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports req_valid, input, 2, one request-valid bit per requester (bit 0 = requester 0, bit 1 = requester 1).
REQ-005 SHALL have ports req_ready, output, 2, one grant/accept bit per requester.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W each, signed operands A and B per requester.
REQ-007 SHALL have ports req0_op, req1_op, input, 2 each, with encoding 00 add, 01 sub, 10 and, 11 xor.
REQ-008 SHALL have ports req0_setcc, req1_setcc, input, 1 each; 1 = commit the condition codes on completion.
REQ-009 SHALL have port rsp_valid, output, 1, result available.
REQ-010 SHALL have port rsp_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-012 SHALL have port rsp_data, output, W, the signed result.
REQ-013 SHALL have port rsp_cc, output, 3, the flags of this result: [2] ZF, [1] SF, [0] OF.
REQ-014 SHALL have port cc_q, output, 3, the architectural condition-code register, same bit order as rsp_cc.
REQ-015 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-017 SHALL drive req_ready combinationally: nonzero only in IDLE, at most one bit set, and set only for a requester whose req_valid is 1.
REQ-018 SHALL arbitrate round-robin:
  - one requester valid: grant it;
  - both valid: grant the requester not served last;
  - last-served pointer updates only on an accept.
REQ-019 SHALL, on accept (req_valid[i] & req_ready[i] at an edge), latch that requester's a, b, op, setcc and id, then go IDLE->EXEC.
REQ-020 SHALL, in EXEC, compute the result combinationally from the latched operands, register rsp_data, rsp_cc and rsp_id at the next edge, and go EXEC->RESP.
REQ-021 SHALL make rsp_valid a registered signal, 1 only in RESP.
REQ-022 SHALL give latency of exactly 2 edges from accept to rsp_valid=1.
REQ-023 SHALL give back-to-back throughput of one operation per 3 cycles when rsp_ready is held 1.
REQ-024 SHALL hold rsp_data, rsp_cc and rsp_id stable in RESP while rsp_ready=0; stalls are unbounded.
REQ-025 SHALL, on rsp_valid & rsp_ready at an edge, go RESP->IDLE; new requests are granted only from the following IDLE cycle.
REQ-026 SHALL compute results as follows:
  - add: a+b;
  - sub: a-b;
  - and: a&b;
  - xor: a^b;
  - all modulo 2^W, two's complement.
REQ-027 SHALL set ZF = (result==0) and SF = result[W-1].
REQ-028 SHALL set OF as follows:
  - add: sign(a)==sign(b) and sign(result)!=sign(a);
  - sub: sign(a)!=sign(b) and sign(result)!=sign(a);
  - and, xor: OF=0.
REQ-029 SHALL load cc_q with the computed flags at the EXEC->RESP edge if the latched setcc=1; otherwise cc_q holds.
REQ-030 SHALL ignore changes on req_* inputs while not in IDLE; the latched operands are used.
REQ-031 SHALL not drop a request: a valid requester deasserting req_valid before it is granted is legal and simply not served.

Reset
REQ-032 SHALL, with rst=1 at an edge, reset as follows, overriding all other activity including mid-EXEC or mid-RESP:
  - state=IDLE;
  - rsp_valid=0, rsp_data=0, rsp_cc=3'b000, rsp_id=0;
  - cc_q=3'b100 (ZF set);
  - last-served pointer=1, so requester 0 wins the first tie.
REQ-033 SHALL force req_ready=2'b00 and busy=0 while rst=1; no in-flight operation completes or updates cc_q.

Verification
REQ-034 SHALL cover single add: req0 a=5, b=-5, op=00, setcc=1 -> 2 edges later rsp_valid=1, rsp_id=0, rsp_data=0, rsp_cc=100, cc_q=100.
REQ-035 SHALL cover overflow: req1 a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=00 -> rsp_data=0x8000_0000_0000_0000, rsp_cc=011; sub a=0x8000_0000_0000_0000, b=1 -> rsp_data=0x7FFF_FFFF_FFFF_FFFF, rsp_cc=001.
REQ-036 SHALL cover arbitration: both valid continuously after reset -> grants alternate 0,1,0,1; req_ready is never 2'b11.
REQ-037 SHALL cover setcc=0: xor a=3, b=3 with setcc=0 -> rsp_cc=100, cc_q unchanged from the prior value.
REQ-038 SHALL cover backpressure: rsp_ready=0 for 10 cycles in RESP -> outputs stable, req_ready=00; rsp_ready=1 -> IDLE next cycle.
REQ-039 SHALL cover reset mid-op: rst=1 during EXEC -> next cycle rsp_valid=0, cc_q=100, state IDLE; the pending result is never presented.
